// File: rtl/ehl_clock_switch_ctrl.sv
// Clock-source switch controller driving the sel input of ehl_clock_mux.
// Accepts switch requests, checks target health, holds off during the settle window, optional failover.
module ehl_clock_switch_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter bit          RESET_SEL     = 1'b0,
  parameter bit          AUTO_FAILOVER = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  input  logic       req_sel,
  output logic       req_ready,
  input  logic [1:0] src_ok,
  output logic       sel,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       failover
);

  localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

  typedef enum logic {
    IDLE,
    SWITCH
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [1:0]    ok_meta;
  logic [1:0]    ok_s;
  logic          accept;
  logic          alt_sel;
  logic          want_failover;

  // Health bits come from other clock domains; two flops per bit before use.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ok_meta <= 2'b00;
      ok_s    <= 2'b00;
    end else begin
      ok_meta <= src_ok;
      ok_s    <= ok_meta;
    end
  end

  assign req_ready     = (state == IDLE);
  assign busy          = (state == SWITCH);
  assign accept        = req_valid && (state == IDLE);
  assign alt_sel       = ~sel;
  // An accepted request, even a no-op or a rejected one, takes priority over failover.
  assign want_failover = AUTO_FAILOVER && (state == IDLE) && !req_valid &&
                         !ok_s[sel] && ok_s[alt_sel];

  // NOTE: all state and outputs here use <= so every branch sees the pre-edge sel/count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      sel      <= RESET_SEL;
      count    <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      failover <= 1'b0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      failover <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (req_sel == sel) begin
              done <= 1'b1;
            end else if (!ok_s[req_sel]) begin
              err <= 1'b1;
            end else begin
              sel   <= req_sel;
              state <= SWITCH;
              count <= SETTLE_LOAD;
            end
          end else if (want_failover) begin
            sel      <= alt_sel;
            state    <= SWITCH;
            count    <= SETTLE_LOAD;
            failover <= 1'b1;
          end
        end
        SWITCH: begin
          // Source health and new requests are deliberately ignored until the mux has settled.
          if (count == '0) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            count <= count - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ehl_clock_switch_ctrl.md
Name: ehl_clock_switch_ctrl

Overview:
Control stage that sits directly upstream of ehl_clock_mux and drives its sel input. It runs on an always-on reference clock and accepts clock-source switch requests over a valid/ready handshake. It checks that the target source is healthy, then holds off new requests for a programmable settle window while the mux completes its glitch-free hand-over. Optionally it fails over automatically when the active source reports loss of health.

Parameters:
SETTLE_CYCLES, 8, number of clk cycles busy is held after sel changes (legal range 1..255; counter width $clog2(SETTLE_CYCLES+1))
RESET_SEL, 0, value of sel during and after reset (0 selects clk_0, 1 selects clk_1)
AUTO_FAILOVER, 1, 1 enables automatic switch away from an unhealthy active source; 0 disables it

Ports:
clk  input  1  always-on reference clock; all logic on rising edge
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  switch request valid
req_sel  input  1  requested source (0 = clk_0, 1 = clk_1)
req_ready  output  1  request can be accepted; combinational, equals (state == IDLE)
src_ok  input  2  per-source health (e.g. PLL lock); asynchronous, bit i applies to clk_i
sel  output  1  registered mux select, connects to ehl_clock_mux sel
busy  output  1  high while in SWITCH state
done  output  1  one-cycle pulse: request completed or was a no-op
err  output  1  one-cycle pulse: request rejected because the target source is not ok
failover  output  1  one-cycle pulse: automatic switch started

Behaviour:
- Reset (asynchronous, immediate, including mid-switch): state=IDLE, sel=RESET_SEL, busy=0, done=0, err=0, failover=0, settle counter=0, sync flops=0.
- src_ok passes through a 2-flop synchronizer per bit (ok_s). A change on src_ok is visible in ok_s after the 2nd rising edge.
- States: IDLE, SWITCH. done, err and failover are registered pulses and are never high for more than one cycle.
- A request is accepted at edge E when req_valid=1 and state=IDLE.
  - req_sel==sel: no state change. done=1 for the cycle after E.
  - req_sel!=sel and ok_s[req_sel]==0: rejected. err=1 for the cycle after E. sel is unchanged.
  - req_sel!=sel and ok_s[req_sel]==1: at E, sel<=req_sel, state<=SWITCH, counter<=SETTLE_CYCLES-1.
- SWITCH: counter decrements each edge. At the edge where it reads 0, state<=IDLE and done<=1. busy is therefore high for exactly SETTLE_CYCLES cycles (edges E..E+SETTLE_CYCLES-1). done is high in the cycle after edge E+SETTLE_CYCLES-1, and req_ready=1 in that same cycle.
- req_valid/req_sel changes during SWITCH are ignored. The requester must hold req_valid until it sees req_ready.
- src_ok changes during SWITCH are ignored; the switch always completes.
- Failover (AUTO_FAILOVER=1): in IDLE with no request accepted at that edge, if ok_s[sel]==0 and ok_s[~sel]==1, the block performs the same sequence as an accepted switch to ~sel and sets failover=1 for one cycle. On completion it pulses done.
  - An accepted request has priority over failover at the same edge.
  - If both ok_s bits are 0, no action is taken and sel holds.
- After reset both ok_s bits are 0, so neither failover nor any switch can occur before the synchronizer fills.
- AUTO_FAILOVER=0: the failover output is tied 0 and ok_s[sel] loss is ignored.

Test Plan:
- Reset then idle: reset_n low mid-run -> sel=RESET_SEL(0), busy=0, all pulses 0, req_ready=1 immediately. With src_ok=2'b11 and no requests, sel stays 0 forever.
- Normal switch: src_ok=2'b11, synced; request req_sel=1 accepted at edge E -> sel=1 after E, busy high 8 cycles, done high exactly 1 cycle after E+7, req_ready low during busy. Reverse request returns sel=0 with identical timing.
- No-op and reject: req_sel=sel -> done 1 cycle, busy never high. src_ok=2'b01 with sel=0 and req_sel=1 -> err 1 cycle, sel stays 0, no done.
- Failover: sel=0, src_ok 11->10 -> within 3 edges failover pulses, sel=1, busy 8 cycles, then done. A following src_ok=2'b00 leaves sel=1 with no further pulses.
- Priority and ignore: request req_sel=0 and a failover condition at the same edge -> request wins. src_ok drop and req_valid toggling during SWITCH -> the switch still completes after 8 cycles.
- Reset mid-SWITCH at counter=3: sel jumps to RESET_SEL, busy drops asynchronously, and no done is produced after reset release. Pair with ehl_clock_mux and confirm clk_out follows the selected source after each done.
